// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - CPU, secondary-master and memory port signals of the arbiter
interface mem_port_arbiter_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      cpu_addr;
    logic [31:0]      cpu_wdata;
    logic             cpu_rstrb;
    logic [3:0]       cpu_wstrb;
    logic [31:0]      cpu_rdata;
    logic             dma_req;
    logic [31:0]      dma_addr;
    logic [31:0]      dma_wdata;
    logic [3:0]       dma_wstrb;
    logic             dma_ack;
    logic [31:0]      dma_rdata;
    logic             dma_rvalid;
    logic             dma_starved;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             mem_rstrb;
    logic [3:0]       mem_wstrb;
    logic [31:0]      mem_rdata;
    logic [CNT_W-1:0] cpu_acc_cnt;
    logic [CNT_W-1:0] dma_acc_cnt;

    // The arbiter side
    modport slave (
        input  cpu_addr, cpu_wdata, cpu_rstrb, cpu_wstrb,
        input  dma_req, dma_addr, dma_wdata, dma_wstrb,
        input  mem_rdata,
        output cpu_rdata, dma_ack, dma_rdata, dma_rvalid, dma_starved,
        output mem_addr, mem_wdata, mem_rstrb, mem_wstrb,
        output cpu_acc_cnt, dma_acc_cnt
    );

    // The environment side (masters and memory)
    modport master (
        output cpu_addr, cpu_wdata, cpu_rstrb, cpu_wstrb,
        output dma_req, dma_addr, dma_wdata, dma_wstrb,
        output mem_rdata,
        input  cpu_rdata, dma_ack, dma_rdata, dma_rvalid, dma_starved,
        input  mem_addr, mem_wdata, mem_rstrb, mem_wstrb,
        input  cpu_acc_cnt, dma_acc_cnt
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - CPU-priority memory port sharing with a secondary bus master
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 64,
    parameter int CNT_W        = 32
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int SCW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, CPU_RD, DMA_RD} state_e;

    logic             cpu_act;
    logic             dma_ack;
    logic             dma_rd_ack;
    state_e           state_q, state_d;
    logic             rvalid_q;
    logic [31:0]      rdata_q;
    logic [SCW-1:0]   starve_q, starve_d;
    logic             starved_q;
    logic [CNT_W-1:0] cpu_cnt_q, dma_cnt_q;

    assign cpu_act    = bus.cpu_rstrb | (|bus.cpu_wstrb);
    assign dma_ack    = bus.dma_req & ~cpu_act;
    assign dma_rd_ack = dma_ack & (bus.dma_wstrb == 4'b0000);

    // Port mux: CPU always owns the port when it strobes, DMA fills idle cycles
    always_comb begin
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_rstrb = 1'b0;
        bus.mem_wstrb = 4'b0000;
        if (cpu_act) begin
            bus.mem_rstrb = bus.cpu_rstrb;
            bus.mem_wstrb = bus.cpu_wstrb;
        end else if (bus.dma_req) begin
            bus.mem_addr  = bus.dma_addr;
            bus.mem_wdata = bus.dma_wdata;
            bus.mem_wstrb = bus.dma_wstrb;
            bus.mem_rstrb = (bus.dma_wstrb == 4'b0000);
        end
    end

    assign bus.dma_ack   = dma_ack;
    assign bus.cpu_rdata = bus.mem_rdata;

    // Tracks which master owns the read data arriving next cycle
    always_comb begin
        state_d = IDLE;
        if (bus.cpu_rstrb) begin
            state_d = CPU_RD;
        end else if (dma_rd_ack) begin
            state_d = DMA_RD;
        end
    end

    // Read-return FSM; rdata_q keeps the last DMA read word for the hold phase
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= (state_d == DMA_RD);
            if (state_q == DMA_RD) begin
                rdata_q <= bus.mem_rdata;
            end
        end
    end

    // Memory returns data in the DMA_RD cycle, so the word is steered straight through then
    assign bus.dma_rvalid = rvalid_q;
    assign bus.dma_rdata  = (state_q == DMA_RD) ? bus.mem_rdata : rdata_q;

    // Consecutive denied-request run length, saturating
    always_comb begin
        starve_d = '0;
        if (bus.dma_req && !dma_ack) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
        end
    end

    // Starvation count and flag; the flag is registered from the next count
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q  <= '0;
            starved_q <= 1'b0;
        end else begin
            starve_q  <= starve_d;
            starved_q <= (starve_d == STARVE_MAX);
        end
    end

    assign bus.dma_starved = starved_q;

    // Free-running access counters, wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_cnt_q <= '0;
            dma_cnt_q <= '0;
        end else begin
            cpu_cnt_q <= cpu_cnt_q + CNT_W'(cpu_act);
            dma_cnt_q <= dma_cnt_q + CNT_W'(dma_ack);
        end
    end

    assign bus.cpu_acc_cnt = cpu_cnt_q;
    assign bus.dma_acc_cnt = dma_cnt_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int LIMIT = 4;
    localparam int CW    = 4;

    logic clk;
    logic rst;

    mem_port_arbiter_if #(.CNT_W(CW)) bus ();

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        bit          rst;
        logic [31:0] cpu_addr;
        logic [31:0] cpu_wdata;
        bit          cpu_rstrb;
        logic [3:0]  cpu_wstrb;
        bit          dma_req;
        logic [31:0] dma_addr;
        logic [31:0] dma_wdata;
        logic [3:0]  dma_wstrb;
        logic [31:0] mem_rdata;
        int          p_ack;
        int          p_rv;
        longint      p_rd;
        int          p_st;
        int          p_cc;
        int          p_dc;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    task automatic add(input bit chk, input bit r,
                       input logic [31:0] ca, input logic [31:0] cw, input bit cr, input logic [3:0] cs,
                       input bit dq, input logic [31:0] da, input logic [31:0] dw, input logic [3:0] ds,
                       input logic [31:0] mr);
        vec_t v;
        v.chk = chk; v.rst = r;
        v.cpu_addr = ca; v.cpu_wdata = cw; v.cpu_rstrb = cr; v.cpu_wstrb = cs;
        v.dma_req = dq; v.dma_addr = da; v.dma_wdata = dw; v.dma_wstrb = ds;
        v.mem_rdata = mr;
        v.p_ack = -1; v.p_rv = -1; v.p_rd = -1; v.p_st = -1; v.p_cc = -1; v.p_dc = -1;
        vq.push_back(v);
    endtask

    task automatic idle(input bit r, input logic [31:0] mr);
        add(1, r, 32'h0, 32'h0, 0, 4'h0, 0, 32'h0, 32'h0, 4'h0, mr);
    endtask

    // Hand-computed literal expectations for the last added cycle (-1 = don't care)
    task automatic pin(input int ack, input int rv, input longint rd, input int st, input int cc, input int dc);
        int n;
        n = vq.size() - 1;
        vq[n].p_ack = ack; vq[n].p_rv = rv; vq[n].p_rd = rd;
        vq[n].p_st = st; vq[n].p_cc = cc; vq[n].p_dc = dc;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Model state: registered behaviour expressed as plain history facts
    bit          m_pend;
    logic [31:0] m_last;
    int          m_deny;
    int          m_cc;
    int          m_dc;

    initial begin
        vec_t        v;
        bit          act, ack;
        logic [31:0] e_addr, e_wdata, e_rdata;
        bit          e_rstrb;
        logic [3:0]  e_wstrb;

        // Reset
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1, 32'h0);                                                         pin(0, 0, 0, 0, 0, 0);
        // CPU-only read
        add(1, 0, 32'h10, 0, 1, 4'h0, 0, 0, 0, 0, 32'h0);                       pin(0, 0, 0, 0, 0, 0);
        idle(0, 32'hDEADBEEF);                                                  pin(0, 0, 0, 0, 1, 0);
        // DMA read with CPU idle
        add(1, 0, 0, 0, 0, 4'h0, 1, 32'h200, 0, 4'h0, 32'h0);                   pin(1, 0, 0, 0, 1, 0);
        idle(0, 32'h12345678);                                                  pin(0, 1, 32'h12345678, 0, 1, 1);
        // Collision: CPU byte write vs DMA write
        for (int i = 0; i < 3; i++) begin
            add(1, 0, 32'h20, 32'h11, 0, 4'b0001, 1, 32'h300, 32'hA5A5A5A5, 4'hF, 32'h0);
            pin(0, 0, -1, 0, -1, -1);
        end
        add(1, 0, 0, 0, 0, 4'h0, 1, 32'h300, 32'hA5A5A5A5, 4'hF, 32'h0);        pin(1, 0, -1, 0, 4, 1);
        idle(0, 32'h0);                                                         pin(0, 0, 32'h12345678, 0, 4, 2);
        // Starvation: six CPU reads against a pending DMA read
        for (int i = 0; i < 6; i++) begin
            add(1, 0, 32'h40, 0, 1, 4'h0, 1, 32'h400, 0, 4'h0, 32'h0);
            pin(0, 0, -1, (i >= 4) ? 1 : 0, -1, -1);
        end
        add(1, 0, 0, 0, 0, 4'h0, 1, 32'h400, 0, 4'h0, 32'h0);                   pin(1, 0, -1, 1, 10, 2);
        idle(0, 32'h0BADF00D);                                                  pin(0, 1, 32'h0BADF00D, 0, 10, 3);
        // Back-to-back DMA reads
        add(1, 0, 0, 0, 0, 4'h0, 1, 32'h0, 0, 4'h0, 32'h0);                     pin(1, 0, -1, 0, -1, -1);
        add(1, 0, 0, 0, 0, 4'h0, 1, 32'h4, 0, 4'h0, 32'hAAAA0000);              pin(1, 1, 32'hAAAA0000, 0, -1, 4);
        idle(0, 32'hBBBB0004);                                                  pin(0, 1, 32'hBBBB0004, 0, 10, 5);
        idle(0, 32'h0);                                                         pin(0, 0, 32'hBBBB0004, 0, 10, 5);
        // CPU counter wraps at 2^CW
        for (int i = 0; i < 6; i++) add(1, 0, 32'h80 + i, 32'h55, 0, 4'b1100, 0, 0, 0, 0, 32'h0);
        idle(0, 32'h0);                                                         pin(0, 0, -1, 0, 0, 5);
        // Reset while a DMA read is acked
        add(1, 1, 0, 0, 0, 4'h0, 1, 32'h500, 0, 4'h0, 32'h0);                   pin(1, 0, -1, -1, -1, -1);
        idle(0, 32'hFFFFFFFF);                                                  pin(0, 0, 0, 0, 0, 0);
        idle(0, 32'h0);

        m_pend = 0; m_last = 0; m_deny = 0; m_cc = 0; m_dc = 0;

        @(posedge clk);
        #1;
        foreach (vq[k]) begin
            v   = vq[k];
            cyc = k;
            rst           = v.rst;
            bus.cpu_addr  = v.cpu_addr;
            bus.cpu_wdata = v.cpu_wdata;
            bus.cpu_rstrb = v.cpu_rstrb;
            bus.cpu_wstrb = v.cpu_wstrb;
            bus.dma_req   = v.dma_req;
            bus.dma_addr  = v.dma_addr;
            bus.dma_wdata = v.dma_wdata;
            bus.dma_wstrb = v.dma_wstrb;
            bus.mem_rdata = v.mem_rdata;

            act = v.cpu_rstrb || (v.cpu_wstrb != 0);
            ack = v.dma_req && !act;
            if (act) begin
                e_addr = v.cpu_addr; e_wdata = v.cpu_wdata; e_rstrb = v.cpu_rstrb; e_wstrb = v.cpu_wstrb;
            end else if (v.dma_req) begin
                e_addr = v.dma_addr; e_wdata = v.dma_wdata; e_rstrb = (v.dma_wstrb == 0); e_wstrb = v.dma_wstrb;
            end else begin
                e_addr = v.cpu_addr; e_wdata = v.cpu_wdata; e_rstrb = 0; e_wstrb = 0;
            end
            e_rdata = m_pend ? v.mem_rdata : m_last;

            @(negedge clk);
            if (v.chk) begin
                chk("mem_addr",    bus.mem_addr,  e_addr);
                chk("mem_wdata",   bus.mem_wdata, e_wdata);
                chk("mem_rstrb",   32'(bus.mem_rstrb), 32'(e_rstrb));
                chk("mem_wstrb",   32'(bus.mem_wstrb), 32'(e_wstrb));
                chk("dma_ack",     32'(bus.dma_ack),   32'(ack));
                chk("cpu_rdata",   bus.cpu_rdata, v.mem_rdata);
                chk("dma_rvalid",  32'(bus.dma_rvalid), 32'(m_pend));
                chk("dma_rdata",   bus.dma_rdata, e_rdata);
                chk("dma_starved", 32'(bus.dma_starved), 32'(m_deny >= LIMIT));
                chk("cpu_acc_cnt", 32'(bus.cpu_acc_cnt), 32'(m_cc % (1 << CW)));
                chk("dma_acc_cnt", 32'(bus.dma_acc_cnt), 32'(m_dc % (1 << CW)));
                if (v.p_ack >= 0) chk("pin_ack",     32'(bus.dma_ack),     32'(v.p_ack));
                if (v.p_rv  >= 0) chk("pin_rvalid",  32'(bus.dma_rvalid),  32'(v.p_rv));
                if (v.p_rd  >= 0) chk("pin_rdata",   bus.dma_rdata,        32'(v.p_rd));
                if (v.p_st  >= 0) chk("pin_starved", 32'(bus.dma_starved), 32'(v.p_st));
                if (v.p_cc  >= 0) chk("pin_cpu_cnt", 32'(bus.cpu_acc_cnt), 32'(v.p_cc));
                if (v.p_dc  >= 0) chk("pin_dma_cnt", 32'(bus.dma_acc_cnt), 32'(v.p_dc));
            end

            @(posedge clk);
            if (v.rst) begin
                m_pend = 0; m_last = 0; m_deny = 0; m_cc = 0; m_dc = 0;
            end else begin
                if (m_pend) m_last = v.mem_rdata;
                m_pend = ack && (v.dma_wstrb == 0);
                m_deny = (v.dma_req && !ack) ? ((m_deny + 1 > LIMIT) ? LIMIT : m_deny + 1) : 0;
                m_cc   = (m_cc + (act ? 1 : 0)) % (1 << CW);
                m_dc   = (m_dc + (ack ? 1 : 0)) % (1 << CW);
            end
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single memory port (32-bit addr/wdata/rdata, read strobe, 4-bit write strobe) with one secondary bus master (DMA/loader/debug).
- The CPU has no stall input, so it holds absolute priority and sees zero added latency.
- The secondary master gets only cycles in which the CPU issues no strobe, using a req/ack handshake and a registered read-return path.
- Provides a starvation flag and access counters for debugging.

Parameters:
- STARVE_LIMIT, 64, number of consecutive denied dma_req cycles after which dma_starved asserts.
- CNT_W, 32, width of the access counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cpu_addr  in  32  CPU memory address
- cpu_wdata  in  32  CPU write data
- cpu_rstrb  in  1  CPU read strobe
- cpu_wstrb  in  4  CPU byte write strobes
- cpu_rdata  out  32  read data to CPU
- dma_req  in  1  secondary master access request
- dma_addr  in  32  secondary address
- dma_wdata  in  32  secondary write data
- dma_wstrb  in  4  byte write strobes; 4'b0000 means read
- dma_ack  out  1  access issued to memory this cycle
- dma_rdata  out  32  read data to secondary master
- dma_rvalid  out  1  dma_rdata valid pulse
- dma_starved  out  1  starvation flag
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rstrb  out  1  memory read strobe
- mem_wstrb  out  4  memory byte write strobes
- mem_rdata  in  32  memory read data, valid 1 cycle after mem_rstrb
- cpu_acc_cnt  out  CNT_W  CPU accesses issued
- dma_acc_cnt  out  CNT_W  DMA accesses issued

Behaviour:
- cpu_act = cpu_rstrb | (|cpu_wstrb).
- Grant and port mux are combinational:
  - cpu_act=1: mem_* = cpu_*.
  - else if dma_req=1: mem_addr=dma_addr, mem_wdata=dma_wdata, mem_wstrb=dma_wstrb, mem_rstrb=(dma_wstrb==0).
  - else: mem_addr=cpu_addr, mem_wdata=cpu_wdata, both strobes 0.
- dma_ack = dma_req & ~cpu_act. dma_ack is asserted in the same cycle the access appears on mem_*.
- Secondary master rule: hold dma_req, dma_addr, dma_wdata and dma_wstrb stable from dma_req rising until the cycle dma_ack=1 inclusive. It may issue a new request the cycle after ack (back-to-back allowed).
- A DMA write completes at ack; it never produces dma_rvalid.
- cpu_rdata = mem_rdata, combinational pass-through. The CPU timing is unchanged.
- Read-return FSM with states IDLE, CPU_RD, DMA_RD:
  - Next state is CPU_RD if cpu_rstrb is issued, DMA_RD if a DMA read is acked, otherwise IDLE. Transitions occur every cycle.
  - In DMA_RD: dma_rvalid=1 and dma_rdata=mem_rdata, registered-through so that both are valid in the cycle after ack.
  - When not in DMA_RD: dma_rvalid=0 and dma_rdata holds its last value.
- Simultaneous CPU strobe and dma_req: CPU wins, dma_ack=0, DMA request stays pending.
- Starvation counter:
  - Increments on each cycle with dma_req & ~dma_ack, saturating at STARVE_LIMIT.
  - Clears on dma_ack or dma_req=0.
  - dma_starved = (count == STARVE_LIMIT), registered.
- Access counters:
  - cpu_acc_cnt increments on each cycle with cpu_act.
  - dma_acc_cnt increments on each dma_ack.
  - Both wrap modulo 2^CNT_W.
- Reset (synchronous):
  - FSM goes to IDLE; dma_rvalid=0, dma_rdata=0, dma_starved=0, starve count=0, both access counters=0.
  - A DMA read acked in the cycle rst is asserted returns no dma_rvalid.
  - Combinational outputs follow inputs during reset; dma_ack stays functional.

Test Plan:
- CPU only: cpu_rstrb=1, cpu_addr=0x10 for 1 cycle, mem_rdata=0xDEADBEEF next cycle -> mem_addr=0x10, mem_rstrb=1 same cycle; cpu_rdata=0xDEADBEEF; dma_rvalid stays 0; cpu_acc_cnt=1.
- DMA read, CPU idle: dma_req=1, dma_addr=0x200, dma_wstrb=0 -> dma_ack=1 and mem_rstrb=1 same cycle; next cycle dma_rvalid=1, dma_rdata=mem_rdata (0x12345678); dma_acc_cnt=1.
- Collision: cpu_wstrb=4'b0001 for 3 cycles while dma_req=1 (write, dma_wstrb=4'b1111, wdata=0xA5A5A5A5) -> dma_ack=0 for 3 cycles, mem_wstrb=4'b0001; 4th cycle dma_ack=1, mem_wstrb=4'b1111, mem_wdata=0xA5A5A5A5; no dma_rvalid.
- Starvation with STARVE_LIMIT=4: cpu_rstrb held 1 for 6 cycles with dma_req=1 -> dma_starved=1 from the cycle after the 4th denied cycle; clears the cycle after dma_ack.
- Back-to-back DMA reads at 0x0 and 0x4 on consecutive cycles -> dma_ack 2 consecutive cycles, dma_rvalid 2 consecutive cycles carrying the respective mem_rdata values.
- Reset mid-read: DMA read acked, rst=1 the same cycle -> next cycle dma_rvalid=0, all counters 0, dma_starved=0.
